mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 111 +++++++++++
 tb/tb_mem_arbiter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) round-robin arbiter onto one shared bus; 3-cycle minimum latency.
// Requests stall until the owner's one-cycle ack; a BUSY bus cycle aborts after TIMEOUT cycles.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic [31:0] i_rdata,
    output logic        i_ack,
    input  logic        d_req,
    input  logic        d_drw,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic [31:0] d_rdata,
    output logic        d_ack,
    output logic        i_stall,
    output logic        d_stall,
    output logic        b_req,
    output logic        b_drw,
    output logic [31:0] b_addr,
    output logic [31:0] b_wdata,
    input  logic [31:0] b_rdata,
    input  logic        b_ready,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nxt;
    logic        owner;      // 0 = fetch, 1 = data
    logic        last_win;
    logic [7:0]  cnt;
    logic        grant_vld;
    logic        grant_own;
    logic        timeout_hit;

    assign i_stall = i_req & ~i_ack;
    assign d_stall = d_req & ~d_ack;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        grant_vld   = i_req | d_req;
        // Under contention the port that did not win last time goes next.
        grant_own   = (i_req & d_req) ? ~last_win : d_req;
        timeout_hit = (cnt == 8'(TIMEOUT - 1));
        case (state)
            IDLE:    if (grant_vld) state_nxt = BUSY;
            BUSY:    if (b_ready || timeout_hit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner    <= 1'b0;
            last_win <= 1'b0;
            cnt      <= 8'd0;
            b_req    <= 1'b0;
            b_drw    <= 1'b0;
            b_addr   <= 32'd0;
            b_wdata  <= 32'd0;
            i_rdata  <= 32'd0;
            d_rdata  <= 32'd0;
            i_ack    <= 1'b0;
            d_ack    <= 1'b0;
            err      <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner    <= grant_own;
                        last_win <= grant_own;
                        cnt      <= 8'd0;
                        b_req    <= 1'b1;
                        b_drw    <= grant_own & d_drw;
                        b_addr   <= grant_own ? d_addr : i_addr;
                        b_wdata  <= grant_own ? d_wdata : 32'd0;
                    end
                end
                BUSY: begin
                    if (b_ready || timeout_hit) begin
                        b_req <= 1'b0;
                        i_ack <= ~owner;
                        d_ack <= owner;
                        err   <= ~b_ready;
                        // Writes leave the load register alone; an aborted read returns zero.
                        if (!b_drw) begin
                            if (owner) d_rdata <= b_ready ? b_rdata : 32'd0;
                            else       i_rdata <= b_ready ? b_rdata : 32'd0;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: table-driven transactions, ack scoreboard, contention/reset/timeout sequences.
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, i_req, d_req, d_drw, b_ready;
    logic [31:0] i_addr, d_addr, d_wdata, b_rdata;

    logic [31:0] i_rdata, d_rdata, b_addr, b_wdata;
    logic        i_ack, d_ack, i_stall, d_stall, b_req, b_drw, err;

    logic [31:0] t_i_rdata, t_d_rdata, t_b_addr, t_b_wdata;
    logic        t_i_ack, t_d_ack, t_i_stall, t_d_stall, t_b_req, t_b_drw, t_err;

    mem_arbiter u_dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
        .d_req(d_req), .d_drw(d_drw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .i_stall(i_stall), .d_stall(d_stall),
        .b_req(b_req), .b_drw(b_drw), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_rdata(b_rdata), .b_ready(b_ready), .err(err)
    );

    mem_arbiter #(.TIMEOUT(4)) u_to (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(t_i_rdata), .i_ack(t_i_ack),
        .d_req(d_req), .d_drw(d_drw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(t_d_rdata), .d_ack(t_d_ack), .i_stall(t_i_stall), .d_stall(t_d_stall),
        .b_req(t_b_req), .b_drw(t_b_drw), .b_addr(t_b_addr), .b_wdata(t_b_wdata),
        .b_rdata(b_rdata), .b_ready(b_ready), .err(t_err)
    );

    typedef struct {
        logic        port;   // 0 = fetch, 1 = data
        logic        drw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;  // value the bus returns
        int          delay;  // BUSY cycles before b_ready
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[7];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model_i, model_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Ack monitor for the default-TIMEOUT instance.
    always @(negedge clk) begin
        if (!rst && (i_ack || d_ack)) begin
            exp_t e;
            check("ack_exclusive", {31'd0, i_ack & d_ack}, 32'd0);
            check("ack_expected", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("ack_port", {31'd0, d_ack}, {31'd0, e.port});
                check("ack_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
                check("ack_err", {31'd0, err}, {31'd0, e.err});
            end
        end
    end

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_drw = 1'b0; b_ready = 1'b0;
        i_addr = 32'd0; d_addr = 32'd0; d_wdata = 32'd0; b_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_i = 32'd0;
        model_d = 32'd0;
        sb.delete();
    endtask

    task automatic run_txn(input vec_t v);
        exp_t e;
        @(posedge clk); #1;
        if (v.port) begin
            d_req = 1'b1; d_drw = v.drw; d_addr = v.addr; d_wdata = v.wdata;
        end else begin
            i_req = 1'b1; i_addr = v.addr;
        end
        e.port  = v.port;
        e.err   = 1'b0;
        e.rdata = (v.port && v.drw) ? model_d : v.rdata;
        if (!v.drw) begin
            if (v.port) model_d = v.rdata;
            else        model_i = v.rdata;
        end
        sb.push_back(e);
        check("c0_breq", {31'd0, b_req}, 32'd0);
        for (int j = 0; j <= v.delay; j++) begin
            @(posedge clk); #1;
            check("busy_breq", {31'd0, b_req}, 32'd1);
            check("busy_addr", b_addr, v.addr);
            check("busy_drw", {31'd0, b_drw}, {31'd0, v.port & v.drw});
            check("busy_wdata", b_wdata, v.port ? v.wdata : 32'd0);
            check("busy_stall", {31'd0, v.port ? d_stall : i_stall}, 32'd1);
            if (j == v.delay) begin
                b_ready = 1'b1;
                b_rdata = v.rdata;
            end
        end
        @(posedge clk); #1;
        b_ready = 1'b0;
        check("done_breq", {31'd0, b_req}, 32'd0);
        check("done_stall", {31'd0, v.port ? d_stall : i_stall}, 32'd0);
        i_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk); #1;
        check("ack_seen", sb.size(), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   cnt;
        logic seen;

        tbl[0] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0,         32'hDEAD_BEEF, 0};
        tbl[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h1234_5678, 32'hBAD0_BAD0, 4};
        tbl[2] = '{1'b1, 1'b0, 32'h0000_3000, 32'h0,         32'hA5A5_A5A5, 2};
        tbl[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,         32'h0000_0000, 1};
        tbl[4] = '{1'b1, 1'b1, 32'h0000_3004, 32'hCAFE_F00D, 32'h7777_7777, 0};
        tbl[5] = '{1'b1, 1'b0, 32'h0000_4000, 32'h0,         32'hFFFF_FFFF, 0};
        tbl[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'h1357_9BDF, 3};

        do_reset();
        check("rst_breq", {31'd0, b_req}, 32'd0);
        check("rst_bdrw", {31'd0, b_drw}, 32'd0);
        check("rst_baddr", b_addr, 32'd0);
        check("rst_bwdata", b_wdata, 32'd0);
        check("rst_irdata", i_rdata, 32'd0);
        check("rst_drdata", d_rdata, 32'd0);
        check("rst_acks_err", {29'd0, i_ack, d_ack, err}, 32'd0);

        for (int i = 0; i < 7; i++) run_txn(tbl[i]);

        // Contention: after reset the data port wins first, then strict alternation.
        do_reset();
        i_req = 1'b1; i_addr = 32'h500;
        d_req = 1'b1; d_drw = 1'b0; d_addr = 32'h600;
        b_ready = 1'b1; b_rdata = 32'hC0FF_EE00;
        for (int k = 0; k < 4; k++) begin
            e.port = (k % 2 == 0); e.rdata = 32'hC0FF_EE00; e.err = 1'b0;
            sb.push_back(e);
        end
        repeat (11) @(posedge clk);
        #1 i_req = 1'b0; d_req = 1'b0;
        @(posedge clk); #1 b_ready = 1'b0;
        @(negedge clk); #1;
        check("contention_drained", sb.size(), 32'd0);

        // Reset in the middle of BUSY abandons the fetch; a held request re-arbitrates.
        do_reset();
        i_req = 1'b1; i_addr = 32'h800;
        @(posedge clk); #1;
        check("mid_busy_breq", {31'd0, b_req}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        check("after_rst_breq", {31'd0, b_req}, 32'd0);
        check("after_rst_iack", {31'd0, i_ack}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("rearb_breq", {31'd0, b_req}, 32'd1);
        check("rearb_addr", b_addr, 32'h800);
        e.port = 1'b0; e.rdata = 32'h0BAD_F00D; e.err = 1'b0;
        sb.push_back(e);
        b_ready = 1'b1; b_rdata = 32'h0BAD_F00D;
        @(posedge clk); #1 b_ready = 1'b0; i_req = 1'b0;
        @(negedge clk); #1;
        check("rearb_ack_seen", sb.size(), 32'd0);

        // Timeout on the TIMEOUT=4 instance: prime d_rdata, then a read the bus never answers.
        do_reset();
        run_txn('{1'b1, 1'b0, 32'h700, 32'h0, 32'h55AA_55AA, 0});
        check("to_prime_rdata", t_d_rdata, 32'h55AA_55AA);
        @(posedge clk); #1;
        d_req = 1'b1; d_drw = 1'b0; d_addr = 32'h704; b_ready = 1'b0;
        cnt = 0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(posedge clk); #1;
            if (t_b_req) cnt++;
            if (t_d_ack) begin
                seen = 1'b1;
                check("to_breq_cycles", cnt, 32'd4);
                check("to_err", {31'd0, t_err}, 32'd1);
                check("to_rdata", t_d_rdata, 32'd0);
                check("to_iack", {31'd0, t_i_ack}, 32'd0);
            end
        end
        check("to_ack_seen", {31'd0, seen}, 32'd1);
        @(posedge clk); #1;
        check("to_err_pulse", {31'd0, t_err}, 32'd0);
        d_req = 1'b0;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
